// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM pattern filler.
package sram_pkg;

  localparam logic [15:0] ColRed   = 16'hF800;
  localparam logic [15:0] ColGreen = 16'h07E0;
  localparam logic [15:0] ColBlue  = 16'h001F;
  localparam logic [15:0] ColBlack = 16'h0000;
  localparam logic [15:0] ColWhite = 16'hFFFF;

  localparam logic [1:0] ModeBars    = 2'd0;
  localparam logic [1:0] ModeSolid   = 2'd1;
  localparam logic [1:0] ModeChecker = 2'd2;
  localparam logic [1:0] ModeRamp    = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StPulse,
    StHold,
    StFin
  } fill_state_e;

endpackage

// File: rtl/sram_pattern_gen.sv
// Combinational pixel colour for coordinate (x, y) under the selected pattern mode.
module sram_pattern_gen
  import sram_pkg::*;
#(
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 9,
  parameter int unsigned CW     = 11,
  parameter int unsigned DATA_W = 16,
  parameter int unsigned BAR_W  = 80
) (
  input  logic [XW-1:0]     x,
  input  logic [YW-1:0]     y,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_color,
  output logic [DATA_W-1:0] pixel
);

  logic [5:0]    xe;
  logic          y3;
  logic [CW-1:0] c;
  logic [2:0]    k;
  logic [15:0]   rgb;

  always_comb begin
    xe  = 6'(x);
    y3  = 1'(32'(y) >> 3);
    c   = CW'(x) + CW'(y);
    // Bar index by threshold compare instead of a divider; saturates at 7 (white).
    k   = '0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (32'(c) >= i * BAR_W) k = 3'(i);
    end
    rgb = '0;
    unique case (mode)
      ModeBars: begin
        if (k == 3'd7)      rgb = ColWhite;
        else if (k == 3'd6) rgb = ColBlack;
        else begin
          case (k)
            3'd0, 3'd3: rgb = ColRed;
            3'd1, 3'd4: rgb = ColBlue;
            default:    rgb = ColGreen;
          endcase
        end
      end
      ModeSolid:   rgb = fill_color[15:0];
      ModeChecker: rgb = (xe[3] ^ y3) ? ~fill_color[15:0] : fill_color[15:0];
      ModeRamp:    rgb = {xe[4:0], xe[5:0], xe[4:0]};
      default:     rgb = '0;
    endcase
    pixel = DATA_W'(rgb);
  end

endmodule

// File: rtl/sram_pattern_fill.sv
// Fills an H_RES x V_RES SRAM region with a test pattern using a setup/pulse/hold
// write cycle per pixel; bus is released to the display path whenever idle.
module sram_pattern_fill
  import sram_pkg::*;
#(
  parameter int unsigned H_RES      = 640,
  parameter int unsigned V_RES      = 480,
  parameter int unsigned ADDR_W     = 20,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BAR_W      = 80,
  parameter int unsigned WE_SETUP   = 1,
  parameter int unsigned WE_PULSE   = 1,
  parameter int unsigned WE_HOLD    = 1,
  parameter int unsigned AUTO_START = 1,
  parameter int unsigned AUTO_MODE  = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] fill_color,
  output logic              busy,
  output logic              done,
  output logic              init_done,
  output logic              bus_own,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_dq_out,
  output logic              sram_dq_oe,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic              sram_ub_n,
  output logic              sram_lb_n
);

  localparam int unsigned XW   = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int unsigned YW   = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam int unsigned CW   = $clog2(H_RES + V_RES);
  localparam int unsigned TMax = (WE_SETUP > WE_PULSE) ?
                                 ((WE_SETUP > WE_HOLD) ? WE_SETUP : WE_HOLD) :
                                 ((WE_PULSE > WE_HOLD) ? WE_PULSE : WE_HOLD);
  localparam int unsigned TW   = $clog2(TMax + 1);

  fill_state_e       state_q, state_d;
  logic [TW-1:0]     cnt_q, cnt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d, pix;
  logic [1:0]        mode_q, mode_d;
  logic [DATA_W-1:0] color_q, color_d;
  logic              abort_q, abort_d, init_q, init_d, auto_q, auto_d;
  logic              active, launch, phase_end, last_pix, stop_req, advance;

  assign active   = (state_q == StSetup) || (state_q == StPulse) || (state_q == StHold);
  assign launch   = (state_q == StIdle) && (start || auto_q);
  assign last_pix = (x_q == XW'(H_RES - 1)) && (y_q == YW'(V_RES - 1));
  assign stop_req = abort_q || abort;
  assign advance  = (state_q == StHold) && phase_end && !last_pix && !stop_req;

  always_comb begin
    phase_end = 1'b0;
    unique case (state_q)
      StSetup: phase_end = (cnt_q == TW'(WE_SETUP - 1));
      StPulse: phase_end = (cnt_q == TW'(WE_PULSE - 1));
      StHold:  phase_end = (cnt_q == TW'(WE_HOLD - 1));
      default: phase_end = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) state_q <= StIdle;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (launch) state_d = StSetup;
      StSetup: if (phase_end) state_d = StPulse;
      StPulse: if (phase_end) state_d = StHold;
      StHold: begin
        // Final pixel wins over a pending abort.
        if (phase_end) begin
          if (last_pix)      state_d = StFin;
          else if (stop_req) state_d = StIdle;
          else               state_d = StSetup;
        end
      end
      StFin:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy        = active || (state_q == StFin);
    done        = (state_q == StFin);
    bus_own     = active;
    sram_dq_oe  = active;
    sram_ce_n   = !active;
    sram_oe_n   = 1'b1;
    sram_we_n   = (state_q != StPulse);
    sram_ub_n   = !active;
    sram_lb_n   = !active;
    sram_addr   = addr_q;
    sram_dq_out = data_q;
    init_done   = init_q;
  end

  sram_pattern_gen #(
    .XW     (XW),
    .YW     (YW),
    .CW     (CW),
    .DATA_W (DATA_W),
    .BAR_W  (BAR_W)
  ) u_gen (
    .x          (x_d),
    .y          (y_d),
    .mode       (mode_d),
    .fill_color (color_d),
    .pixel      (pix)
  );

  always_comb begin
    cnt_d   = (!active || phase_end) ? '0 : cnt_q + 1'b1;
    x_d     = x_q;
    y_d     = y_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mode_d  = mode_q;
    color_d = color_q;
    abort_d = abort_q;
    init_d  = init_q;
    auto_d  = auto_q;
    if (launch) begin
      x_d     = '0;
      y_d     = '0;
      addr_d  = '0;
      mode_d  = start ? mode : 2'(AUTO_MODE);
      color_d = start ? fill_color : '0;
      abort_d = 1'b0;
      init_d  = 1'b0;
      auto_d  = 1'b0;
    end else if (advance) begin
      if (x_q == XW'(H_RES - 1)) begin
        x_d = '0;
        y_d = y_q + 1'b1;
      end else begin
        x_d = x_q + 1'b1;
      end
      addr_d = addr_q + 1'b1;
    end
    // Pixel data is captured from the generator at the same edge the coordinates move.
    if (launch || advance)  data_d  = pix;
    if (active && abort)    abort_d = 1'b1;
    if (state_q == StFin)   init_d  = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      mode_q  <= '0;
      color_q <= '0;
      abort_q <= 1'b0;
      init_q  <= 1'b0;
      auto_q  <= (AUTO_START != 0);
    end else begin
      cnt_q   <= cnt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mode_q  <= mode_d;
      color_q <= color_d;
      abort_q <= abort_d;
      init_q  <= init_d;
      auto_q  <= auto_d;
    end
  end

endmodule

// File: doc/sram_pattern_fill.md
Name: sram_pattern_fill

Overview:
- Parametrised successor of the framebuffer SRAM initialiser: fills an H_RES x V_RES region of external async SRAM with a selectable test pattern at power-up or on request.
- Drives the SRAM through its own bus port with an explicit drive-enable; a top-level mux/tristate hands the bus to the display readout when bus_own=0.
- Adds over the previous generation: configurable resolution, bar width and WE_N timing; four pattern modes; start/done handshake; abort; re-triggerable fill.

Parameters:
- H_RES, 640, pixels per line
- V_RES, 480, lines
- ADDR_W, 20, SRAM address width; H_RES*V_RES must be <= 2**ADDR_W
- DATA_W, 16, SRAM data width; must be >= 16; patterns are RGB565 in bits [15:0], upper bits zero
- BAR_W, 80, diagonal bar width in (x+y) units, mode 0
- WE_SETUP, 1, cycles with address/data valid before WE_N falls (>=1)
- WE_PULSE, 1, cycles WE_N low (>=1)
- WE_HOLD, 1, cycles data held after WE_N rises (>=1)
- AUTO_START, 1, 1 = begin a fill immediately after reset release
- AUTO_MODE, 0, mode used for the auto-start fill

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- start  in  1  one-cycle request; honoured only in IDLE
- abort  in  1  stop the fill at the next pixel boundary
- mode  in  2  0 diagonal bars, 1 solid, 2 checker 8x8, 3 horizontal ramp; sampled with start
- fill_color  in  DATA_W  colour for modes 1/2; sampled with start
- busy  out  1  fill in progress
- done  out  1  one-cycle pulse when the last pixel's HOLD completes
- init_done  out  1  level; 1 once a fill has completed, cleared by the next start
- bus_own  out  1  1 = this block drives the SRAM bus
- sram_addr  out  ADDR_W  SRAM address
- sram_dq_out  out  DATA_W  write data
- sram_dq_oe  out  1  data drive enable
- sram_ce_n / sram_oe_n / sram_we_n / sram_ub_n / sram_lb_n  out  1 each  SRAM strobes

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-low.
- Reset values: busy=0, done=0, init_done=0, bus_own=0, sram_dq_oe=0, sram_addr=0, sram_dq_out=0, all strobes=1. Reset is honoured mid-fill: outputs take these values at the next edge and the pixel counters clear.
- FSM states: IDLE, SETUP, PULSE, HOLD, FIN.
  - IDLE -> SETUP on start, or on the first cycle after reset release when AUTO_START=1 (mode=AUTO_MODE, fill_color=0).
  - SETUP holds WE_SETUP cycles, then PULSE.
  - PULSE holds WE_PULSE cycles, then HOLD.
  - HOLD holds WE_HOLD cycles. At the end of HOLD: if this was the last pixel -> FIN; else if an abort is latched -> IDLE; else advance to the next pixel -> SETUP.
  - FIN lasts one cycle with done=1 and init_done set, then -> IDLE.
- Outputs while in SETUP/PULSE/HOLD:
  - bus_own=1, busy=1, sram_dq_oe=1, ce_n=0, oe_n=1, ub_n=0, lb_n=0.
  - we_n=0 only in PULSE.
  - sram_addr and sram_dq_out are stable across all three states of a pixel.
- Outputs in IDLE/FIN: bus_own=0, dq_oe=0, strobes=1. busy=0 in IDLE, 1 in FIN.
- Write cost: WE_SETUP+WE_PULSE+WE_HOLD cycles per pixel.
- Scan order: x 0..H_RES-1 within y 0..V_RES-1. sram_addr=y*H_RES+x, generated by an incrementing counter; no multiplier.
- Patterns, where c = x+y (width clog2(H_RES+V_RES)) and k = c/BAR_W:
  - mode 0: k mod 3 = 0 red F800, 1 blue 001F, 2 green 07E0 for k<6; k=6 black 0000; k>=7 white FFFF.
  - mode 1: fill_color.
  - mode 2: fill_color when x[3]^y[3]=0, else ~fill_color.
  - mode 3: {x[4:0], x[5:0], x[4:0]}.
- start while busy is ignored. start and abort in the same IDLE cycle: start wins and abort is ignored.
- abort is latched; a latched abort leaves init_done=0 and produces no done pulse. An abort arriving in the final pixel is overridden: the fill completes normally.
- A new start clears init_done in the cycle it is accepted.

Decomposition:
- Shared package sram_pkg: RGB565 colour constants, mode encodings, FSM state enum.
- One sub-module, sram_pattern_gen: combinational x/y/mode/fill_color -> pixel; the top block registers its output at pixel advance.

Test Plan:
- H_RES=4, V_RES=2, BAR_W=2, timings 1/1/1, auto-start -> 8 writes at addr 0..7; data F800,F800,001F,001F,F800,001F,001F,07E0; done pulses at cycle 25 after reset release; init_done=1 afterwards.
- Timings 2/3/1 -> each pixel lasts 6 cycles; we_n low exactly 3 consecutive cycles per pixel; addr/data unchanged during we_n low; ce_n=0 throughout.
- start with mode=2, fill_color=1234, H=16, V=16 -> addr 8 data EDCB, addr 0 data 1234, addr 136 (x=8,y=8) data 1234.
- abort asserted during pixel 3 of 8 -> exactly 4 pixels written, no done pulse, init_done=0, bus_own=0; a following start completes all 8.
- start pulsed while busy -> ignored (sequence unchanged); rst low mid-PULSE -> we_n=1, bus_own=0 at the next edge; after release with AUTO_START=1, fill restarts at addr 0.
